hazard_forward_unit: RTL
========================

// Module: hazard_forward_unit
// PURPOSE
//  Pipeline hazard/forwarding controller; generates the 2-bit selects for the Forward1/Forward2 operand muxes.
//  - Select encoding: 00 = rd1/rd2, 01 = Result_WriteBack, 10 = Alu_Result_M.
//  - Keeps its own scoreboard of register addresses and write enables for the E, M and W stages.
//  - Drives fetch/decode stalls, decode/execute flushes, and a saturating stall-cycle counter.
// PARAMETERS
//  REG_AW  5   register-address width (x0..x31)
//  CNT_W   16  width of StallCount
// PORTS
//  clk         in   1       rising-edge clock
//  rst_n       in   1       asynchronous active-low reset
//  Rs1D        in   REG_AW  source register 1 of the instruction in decode
//  Rs2D        in   REG_AW  source register 2 of the instruction in decode
//  RdD         in   REG_AW  destination register of the instruction in decode
//  RegWriteD   in   1       decode instruction writes rd
//  LoadD       in   1       decode instruction is a load (ResultSrc = memory)
//  PCSrcE      in   1       taken branch/jump resolved in execute
//  ForwardAE   out  2       select for the Forward1 mux
//  ForwardBE   out  2       select for the Forward2 mux
//  StallF      out  1       hold the PC register
//  StallD      out  1       hold the IF/ID register
//  FlushD      out  1       clear the IF/ID register
//  FlushE      out  1       clear the ID/EX register
//  StallCount  out  CNT_W   number of cycles with StallD=1, saturating
// BEHAVIOUR
//  Scoreboard registers: Rs1E, Rs2E, RdE, RegWriteE, LoadE, RdM, RegWriteM, RdW, RegWriteW.
//  - rst_n low: all scoreboard registers and StallCount clear asynchronously to 0.
//  - rst_n low: all outputs are forced to 0.
//  Every rising clk (rst_n high):
//  - Advance M->W and E->M unconditionally.
//  - D->E captures {Rs1D, Rs2D, RdD, RegWriteD, LoadD}.
//  - If FlushE=1, E instead loads all zeros (bubble).
//  Match(a, b) := (a == b) && (b != 0); x0 never matches.
//  ForwardAE (combinational from registered state; ForwardBE identical using Rs2E):
//  - 10 if RegWriteM && Match(Rs1E, RdM);
//  - else 01 if RegWriteW && Match(Rs1E, RdW);
//  - else 00. 11 is never driven.
//  - When both M and W match, M wins (newest value).
//  LoadStall = LoadE && RegWriteE && (Match(Rs1D, RdE) || Match(Rs2D, RdE)).
//  Priority and outputs:
//  - StallF = StallD = LoadStall && !PCSrcE; taken branch overrides stall because the decode instruction is discarded.
//  - FlushD = PCSrcE.
//  - FlushE = LoadStall || PCSrcE.
//  - Load-use costs exactly 1 bubble: next cycle LoadE=0, so LoadStall drops and the value forwards from W (01).
//  StallCount increments on each clk with StallD=1 and holds at 2^CNT_W-1.
//  Reset mid-stall: all outputs drop immediately (async); the pipeline restarts with no pending hazard.
//  Register file writes on the falling edge, so a W-stage producer is visible to decode reads in the same cycle.
// CONFIGURATION
//  HAZARD_FWD_EN defined (default build):
//  - Forwarding as specified above.
//  HAZARD_FWD_EN undefined (forwarding-free build, smaller area):
//  - ForwardAE = ForwardBE = 00 constant.
//  - RAW stall when (RegWriteE && Match(RsxD, RdE)) || (RegWriteM && Match(RsxD, RdM)) for Rs1D or Rs2D.
//  - This stall replaces LoadStall in the StallF/StallD/FlushE equations.
//  - Branch priority and StallCount are unchanged.
// TESTING
//  1. ALU->ALU back-to-back: add x5 then sub x6,x5,x1 -> next cycle ForwardAE=10, no stall, StallCount=0.
//  2. Distance 2: add x5; nop; or x7,x2,x5 -> ForwardBE=01.
//     Also producer in both M and W for x5 -> ForwardAE=10.
//  3. Load-use: lw x8 then add x9,x8,x8 -> one cycle StallF=StallD=FlushE=1; next cycle ForwardAE=ForwardBE=01; StallCount=1.
//  4. x0 and branch: writes to x0 never forward (selects 00).
//     lw x8 in E with PCSrcE=1 and a dependent decode -> FlushD=FlushE=1, StallD=0.
//  5. Async reset asserted mid-stall -> all outputs 0 immediately; StallCount=0.
//     Saturation check with CNT_W=2: 5 stall cycles -> StallCount=3.
//  6. Build without HAZARD_FWD_EN: add x5; sub x6,x5,x1 -> 2 stall cycles, selects stay 00, StallCount=2.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: operand-forward selects, hazard stalls, branch flushes and a saturating stall counter.
// Define HAZARD_FWD_EN for the forwarding build; leave it undefined for the forwarding-free build.
module hazard_forward_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] RdD,
    input  logic              RegWriteD,
    input  logic              LoadD,
    input  logic              PCSrcE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic [CNT_W-1:0]  StallCount
);

    typedef logic [REG_AW-1:0] reg_t;

    reg_t             rs1_e_q, rs1_e_d;
    reg_t             rs2_e_q, rs2_e_d;
    reg_t             rd_e_q, rd_e_d;
    logic             reg_write_e_q, reg_write_e_d;
    logic             load_e_q, load_e_d;
    reg_t             rd_m_q, rd_m_d;
    logic             reg_write_m_q, reg_write_m_d;
    reg_t             rd_w_q, rd_w_d;
    logic             reg_write_w_q, reg_write_w_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       hazard;
    logic       stall;
    logic       flush_e;

    // x0 is hard-wired, so a write to it never creates a dependency
    function automatic logic match(input reg_t a, input reg_t b);
        return (a == b) && (b != '0);
    endfunction

`ifdef HAZARD_FWD_EN
    // Newest producer wins: M before W
    function automatic logic [1:0] fwd_sel(
        input reg_t rs,
        input reg_t rd_m,
        input logic we_m,
        input reg_t rd_w,
        input logic we_w
    );
        if (we_m && match(rs, rd_m)) return 2'b10;
        if (we_w && match(rs, rd_w)) return 2'b01;
        return 2'b00;
    endfunction
`else
    logic unused_sb;
    assign unused_sb = ^{rs1_e_q, rs2_e_q, load_e_q, rd_w_q, reg_write_w_q};
`endif

    // Forward selects and hazard detection from the scoreboard
    always_comb begin
        fwd_a  = 2'b00;
        fwd_b  = 2'b00;
        hazard = 1'b0;
`ifdef HAZARD_FWD_EN
        fwd_a  = fwd_sel(rs1_e_q, rd_m_q, reg_write_m_q, rd_w_q, reg_write_w_q);
        fwd_b  = fwd_sel(rs2_e_q, rd_m_q, reg_write_m_q, rd_w_q, reg_write_w_q);
        hazard = load_e_q && reg_write_e_q &&
                 (match(Rs1D, rd_e_q) || match(Rs2D, rd_e_q));
`else
        hazard = (reg_write_e_q &&
                  (match(Rs1D, rd_e_q) || match(Rs2D, rd_e_q))) ||
                 (reg_write_m_q &&
                  (match(Rs1D, rd_m_q) || match(Rs2D, rd_m_q)));
`endif
        stall   = hazard && !PCSrcE;
        flush_e = hazard || PCSrcE;
    end

    // Next scoreboard state: E takes decode or a bubble, M and W always advance
    always_comb begin
        rs1_e_d       = flush_e ? '0 : Rs1D;
        rs2_e_d       = flush_e ? '0 : Rs2D;
        rd_e_d        = flush_e ? '0 : RdD;
        reg_write_e_d = flush_e ? 1'b0 : RegWriteD;
        load_e_d      = flush_e ? 1'b0 : LoadD;
        rd_m_d        = rd_e_q;
        reg_write_m_d = reg_write_e_q;
        rd_w_d        = rd_m_q;
        reg_write_w_d = reg_write_m_q;
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != '1))
            stall_count_d = stall_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // Scoreboard and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_e_q       <= '0;
            rs2_e_q       <= '0;
            rd_e_q        <= '0;
            reg_write_e_q <= 1'b0;
            load_e_q      <= 1'b0;
            rd_m_q        <= '0;
            reg_write_m_q <= 1'b0;
            rd_w_q        <= '0;
            reg_write_w_q <= 1'b0;
            stall_count_q <= '0;
        end else begin
            rs1_e_q       <= rs1_e_d;
            rs2_e_q       <= rs2_e_d;
            rd_e_q        <= rd_e_d;
            reg_write_e_q <= reg_write_e_d;
            load_e_q      <= load_e_d;
            rd_m_q        <= rd_m_d;
            reg_write_m_q <= reg_write_m_d;
            rd_w_q        <= rd_w_d;
            reg_write_w_q <= reg_write_w_d;
            stall_count_q <= stall_count_d;
        end
    end

    // Outputs are held low while reset is asserted
    assign ForwardAE  = rst_n ? fwd_a : 2'b00;
    assign ForwardBE  = rst_n ? fwd_b : 2'b00;
    assign StallF     = rst_n & stall;
    assign StallD     = rst_n & stall;
    assign FlushD     = rst_n & PCSrcE;
    assign FlushE     = rst_n & flush_e;
    assign StallCount = rst_n ? stall_count_q : '0;

endmodule
